// File: rtl/stx_buffer_pkg.sv
// Shared definitions for the store buffer: store funct3 encodings and the
// record held in each buffer slot.
package stx_buffer_pkg;

    localparam logic [2:0] FNC_SB = 3'b000;
    localparam logic [2:0] FNC_SH = 3'b001;
    localparam logic [2:0] FNC_SW = 3'b010;

    // Widest word address a 32-bit byte address can carry; narrower AWIDTH
    // values are zero-extended into this field so the record type is fixed.
    localparam int unsigned WADDR_MAX = 30;

    typedef struct packed {
        logic [WADDR_MAX-1:0] addr;
        logic [31:0]          wdata;
        logic [3:0]           we;
    } stx_entry_t;

endpackage

// File: rtl/stx_align.sv
// Combinational store alignment: replicates rs2 across the word and builds the
// byte-enable mask from funct3 and the low address bits. Also reports whether
// the access is misaligned for its width and whether funct3 is not a store.
module stx_align
    import stx_buffer_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] data_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  we_o,
    output logic        misaligned_o,
    output logic        illegal_o
);

    // Decode store width into replicated data and byte enables.
    always_comb begin
        wdata_o      = 32'h0000_0000;
        we_o         = 4'b0000;
        misaligned_o = 1'b0;
        illegal_o    = 1'b0;
        case (funct3_i)
            FNC_SB: begin
                wdata_o = {4{data_i[7:0]}};
                we_o    = 4'b0001 << addr_lo_i;
            end
            FNC_SH: begin
                wdata_o      = {2{data_i[15:0]}};
                we_o         = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                misaligned_o = addr_lo_i[0];
            end
            FNC_SW: begin
                wdata_o      = data_i;
                we_o         = 4'b1111;
                misaligned_o = (addr_lo_i != 2'b00);
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/stx_buffer.sv
// Store buffer for the memory stage: aligns incoming stores, queues them in a
// DEPTH-entry FIFO, drains them to data memory over valid/ready, and flags
// loads that hit the word of any pending store.
// Optional build macro: STX_MISALIGN_TRAP_EN -- misaligned SH/SW are dropped
// and reported on misalign_trap instead of being force-aligned.
module stx_buffer
    import stx_buffer_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned AWIDTH = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [31:0]       st_addr,
    input  logic [31:0]       st_data,
    input  logic [2:0]        st_funct3,
    input  logic [31:0]       ld_check_addr,
    output logic              ld_hazard,
    output logic              empty,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_we
`ifdef STX_MISALIGN_TRAP_EN
    ,
    output logic              misalign_trap
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    stx_entry_t        entries_q [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW:0]       count_q,  count_d;

    logic [31:0]       al_wdata_s;
    logic [3:0]        al_we_s;
    logic              al_mis_s;
    logic              al_illegal_s;
    logic              push_s;
    logic              write_s;
    logic              pop_s;
    stx_entry_t        new_entry_s;
    stx_entry_t        head_s;
    logic [WADDR_MAX-1:0] ld_waddr_s;

    stx_align u_align (
        .funct3_i     (st_funct3),
        .addr_lo_i    (st_addr[1:0]),
        .data_i       (st_data),
        .wdata_o      (al_wdata_s),
        .we_o         (al_we_s),
        .misaligned_o (al_mis_s),
        .illegal_o    (al_illegal_s)
    );

    // No pass-through when full: a same-cycle pop only frees the slot for the next cycle.
    assign st_ready  = (count_q != (PW+1)'(DEPTH));
    assign empty     = (count_q == (PW+1)'(0));
    assign push_s    = st_valid && st_ready;
    assign mem_valid = valid_q[rd_ptr_q];
    assign pop_s     = mem_valid && mem_ready;
    assign head_s    = entries_q[rd_ptr_q];
    assign ld_waddr_s = WADDR_MAX'(ld_check_addr[AWIDTH+1:2]);

    assign new_entry_s.addr  = WADDR_MAX'(st_addr[AWIDTH+1:2]);
    assign new_entry_s.wdata = al_wdata_s;
    assign new_entry_s.we    = al_we_s;

`ifdef STX_MISALIGN_TRAP_EN
    logic misalign_trap_q;

    // Misaligned stores complete the handshake but never reach the FIFO.
    assign write_s = push_s && !al_illegal_s && !al_mis_s;

    // One-cycle trap pulse in the cycle after a misaligned store is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_trap_q <= 1'b0;
        end else begin
            misalign_trap_q <= push_s && !al_illegal_s && al_mis_s;
        end
    end

    assign misalign_trap = misalign_trap_q;
`else
    // Misaligned stores are force-aligned by the aligner; only non-stores are dropped.
    assign write_s = push_s && !al_illegal_s && (al_mis_s || !al_mis_s);
`endif

    // Next-state pointers and occupancy from the write/pop pair.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (write_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({write_s, pop_s})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage, per-slot valid bits, pointers and count; reset drops all pending stores.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (write_s) begin
                entries_q[wr_ptr_q] <= new_entry_s;
            end
            // A write and a pop never target the same slot: writes need a free
            // slot and pops need an occupied one.
            for (int i = 0; i < DEPTH; i++) begin
                if (write_s && (wr_ptr_q == PW'(i))) begin
                    valid_q[i] <= 1'b1;
                end else if (pop_s && (rd_ptr_q == PW'(i))) begin
                    valid_q[i] <= 1'b0;
                end
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Memory port driven from the registered head entry; zero whenever idle.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = 32'h0000_0000;
        mem_we    = 4'b0000;
        if (mem_valid) begin
            mem_addr  = head_s.addr[AWIDTH-1:0];
            mem_wdata = head_s.wdata;
            mem_we    = head_s.we;
        end else begin
            mem_addr  = '0;
            mem_wdata = 32'h0000_0000;
            mem_we    = 4'b0000;
        end
    end

    // Conservative word-granular load hazard against every occupied slot,
    // including the one leaving this cycle; the incoming store is not yet a slot.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (entries_q[i].addr == ld_waddr_s)) begin
                ld_hazard = 1'b1;
            end else begin
                ld_hazard = ld_hazard;
            end
        end
    end

endmodule

// File: doc/stx_buffer.md
Name: stx_buffer

Overview:
- Store-side counterpart of the load extractor in the RISC-V core's memory stage.
- Takes a raw store (byte address, rs2 value, funct3) and aligns it into a word address, replicated write data and 4-bit byte-enable.
- Queues the aligned store in a small FIFO and drains it to data memory over a valid/ready handshake.
- Flags loads whose word address matches any pending store, so the pipeline can stall them.

Parameters:
- DEPTH, 2, number of store-buffer entries; power of two, 2..8.
- AWIDTH, 14, width of the memory word address.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  a store request is offered.
- st_ready  out  1  the buffer can accept a store this cycle.
- st_addr  in  32  store byte address.
- st_data  in  32  raw rs2 value.
- st_funct3  in  3  store width: SB=000, SH=001, SW=010.
- ld_check_addr  in  32  byte address of the load currently in the memory stage.
- ld_hazard  out  1  a pending store targets the same word as ld_check_addr.
- empty  out  1  no stores pending; used for fence and CSR drain.
- mem_valid  out  1  head entry is presented to memory.
- mem_ready  in  1  memory accepts the head entry.
- mem_addr  out  AWIDTH  word address of the head entry.
- mem_wdata  out  32  aligned write data.
- mem_we  out  4  byte write-enables.
- misalign_trap  out  1  present only with STX_MISALIGN_TRAP_EN.

Behaviour:
- Reset (asynchronous, rst_n low):
  - FIFO empty, pointers and count cleared, all entries invalid.
  - Outputs: st_ready=1, empty=1, mem_valid=0, mem_addr=0, mem_wdata=0, mem_we=0, ld_hazard=0, misalign_trap=0.
  - Reset asserted mid-drain discards every pending store; nothing is replayed.
- Accept: a push occurs when st_valid && st_ready. st_ready = !full; there is no pass-through when full, even if a pop happens in the same cycle.
- Alignment, computed at push; a = st_addr[1:0]:
  - SB: wdata = {4{st_data[7:0]}}, we = 4'b0001 << a.
  - SH: wdata = {2{st_data[15:0]}}, we = a[1] ? 4'b1100 : 4'b0011.
  - SW: wdata = st_data, we = 4'b1111.
  - Any other funct3: the request is accepted (handshake completes) but no entry is written; it is a no-op.
  - mem_addr = st_addr[AWIDTH+1:2].
- Latency: an entry pushed in cycle N appears on mem_valid in cycle N+1 at the earliest. Memory outputs come straight from the registered head entry.
- Drain:
  - A pop occurs when mem_valid && mem_ready.
  - While mem_valid && !mem_ready, mem_addr, mem_wdata and mem_we hold stable.
  - When mem_valid=0, mem_addr, mem_wdata and mem_we are 0.
  - Entries drain in strict FIFO order.
- Simultaneous push and pop (not full): both take effect, count is unchanged, pointers wrap modulo DEPTH.
- Full: count==DEPTH drives st_ready=0. A pop in that cycle frees a slot, so st_ready=1 in the next cycle.
- empty = (count==0) and is registered-state based. A no-op store never clears empty.
- ld_hazard (combinational):
  - Asserted when any valid entry's word address equals ld_check_addr[AWIDTH+1:2].
  - The entry being popped this cycle still counts.
  - A store being pushed this cycle does not count.
  - The comparison is word-granular and conservative; byte enables are ignored.

Optional Feature:
- Macro STX_MISALIGN_TRAP_EN.
- Enabled: SH with a[0]=1, or SW with a!=0, is accepted but not buffered, and misalign_trap pulses high for exactly one cycle (cycle after acceptance). All other behaviour is unchanged.
- Disabled: the misalign_trap port does not exist. Misaligned stores are force-aligned by ignoring the low address bits per the table above: SH at a=01 writes bytes 0-1, SW at a=11 writes the full word.

Decomposition:
- Shared core package: FNC_SB/FNC_SH/FNC_SW funct3 constants, and a store-entry record type holding word address, wdata and we.
- Sub-module stx_align: purely combinational alignment (funct3, address low bits, data -> wdata, we, misaligned, illegal). It is instantiated once at the push side.

Test Plan:
- SB addr 0x0000_1003, data 0xAABBCCDD, mem_ready=1 -> next cycle mem_valid=1, mem_addr=0x400, mem_wdata=0xDDDDDDDD, mem_we=4'b1000; popped, empty=1.
- SH addr 0x0000_0006, data 0x1234_5678 -> mem_wdata=0x56785678, mem_we=4'b1100, mem_addr=0x001.
- Backpressure: mem_ready=0, push 3 SW with DEPTH=2 -> st_ready=0 after the 2nd push; outputs stay stable. Raise mem_ready -> 2 drains in order; the 3rd store is accepted the cycle after the first pop.
- Hazard: SW pending at 0x0000_0010, ld_check_addr=0x0000_0013 -> ld_hazard=1; with ld_check_addr=0x14 -> ld_hazard=0. After the pop, ld_hazard=0.
- Assert rst_n with 2 entries pending and mem_valid=1 -> immediately mem_valid=0, empty=1, st_ready=1; no writes occur after release.
- STX_MISALIGN_TRAP_EN: SW at 0x0000_0002 -> misalign_trap=1 for one cycle, mem_valid stays 0. Without the macro -> mem_we=4'b1111, mem_addr=0x000.
